serial_mag_comparator: RTL and testbench

//   Parametrised bit-serial magnitude comparator; successor to the 2-bit combinational equality comparator.

---
 rtl/serial_mag_comparator.sv | 104 ++++++++++
 tb/tb_serial_mag_comparator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator with a start/busy/done handshake.
// Optional macro EARLY_EXIT_EN: end the scan on the first differing bit instead of always scanning WIDTH bits.
module serial_mag_comparator #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx_reg;
    logic             diff_reg;
    logic             dgt_reg;

    logic cur_diff;
    logic cur_gt;
    logic res_diff;
    logic res_gt;
    logic finish;

    // In signed mode a set MSB marks the more negative operand, so the sense flips there only.
    always_comb begin
        cur_diff = a_reg[idx_reg] ^ b_reg[idx_reg];
        cur_gt   = (SIGNED && (idx_reg == MSB_IDX)) ? b_reg[idx_reg] : a_reg[idx_reg];
        res_diff = diff_reg | cur_diff;
        res_gt   = diff_reg ? dgt_reg : cur_gt;
`ifdef EARLY_EXIT_EN
        finish   = (idx_reg == '0) || cur_diff;
`else
        finish   = (idx_reg == '0);
`endif
    end

    // Results are collected privately and only published on entry to DONE,
    // so eq/gt/lt stay low for the whole scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= MSB_IDX;
            diff_reg  <= 1'b0;
            dgt_reg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        idx_reg   <= MSB_IDX;
                        diff_reg  <= 1'b0;
                        dgt_reg   <= 1'b0;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_diff && !diff_reg) begin
                        diff_reg <= 1'b1;
                        dgt_reg  <= cur_gt;
                    end
                    if (finish) begin
                        eq        <= !res_diff;
                        gt        <= res_diff && res_gt;
                        lt        <= res_diff && !res_gt;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg - IW'(1);
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomised self-checking bench: unsigned and signed instances share stimulus and
// are checked against an arithmetic reference for result and latency.
module tb_serial_mag_comparator;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic busy_u, done_u, eq_u, gt_u, lt_u;
    logic busy_s, done_s, eq_s, gt_s, lt_s;

    int n_cmp = 0;
    int n_bad = 0;

    serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .eq(eq_u), .gt(gt_u), .lt(lt_u)
    );

    serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .eq(eq_s), .gt(gt_s), .lt(lt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Edges from the accepting edge (inclusive) until done is visible.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int first_diff;
        first_diff = -1;
        for (int i = 0; i < W; i++)
            if (x[i] != y[i]) first_diff = i;
`ifdef EARLY_EXIT_EN
        if (first_diff >= 0) return W - first_diff + 1;
`endif
        return (first_diff >= -1) ? W + 1 : 0;
    endfunction

    // {eq, gt, lt} from plain arithmetic comparison.
    function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        int xi, yi;
        xi = sgn ? int'($signed(x)) : int'(x);
        yi = sgn ? int'($signed(y)) : int'(y);
        return {xi == yi, xi > yi, xi < yi};
    endfunction

    // Counts scan edges until done; optionally pulses a stray start at scan edge inj.
    task automatic wait_done(input int inj, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done_u) break;
            check("quiet_flags", {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s}, 0);
            check("busy_scan", {busy_u, busy_s}, 2'b11);
            if (inj > 0 && n == inj - 1) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else if (inj > 0 && n == inj) begin
                start = 1'b0;
            end
        end
        if (inj > 0) start = 1'b0;
    endtask

    task automatic check_result(input logic [W-1:0] x, input logic [W-1:0] y);
        check("done_both", {done_u, done_s}, 2'b11);
        check("busy_at_done", {busy_u, busy_s}, 2'b11);
        check("res_unsigned", {eq_u, gt_u, lt_u}, ref_res(x, y, 1'b0));
        check("res_signed", {eq_s, gt_s, lt_s}, ref_res(x, y, 1'b1));
    endtask

    task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
        int n;
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        check("busy_accept", {busy_u, busy_s}, 2'b11);
        check("flags_accept", {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s}, 0);
        wait_done(inj, n);
        check("latency", n + 1, ref_lat(x, y));
        check_result(x, y);
        @(posedge clk); #1;
        check("done_one_cycle", {done_u, done_s}, 0);
        check("busy_cleared", {busy_u, busy_s}, 0);
        check("res_held", {eq_u, gt_u, lt_u, eq_s, gt_s, lt_s},
              {ref_res(x, y, 1'b0), ref_res(x, y, 1'b1)});
        $display("cmp a=%02h b=%02h lat=%0d u=%03b s=%03b", x, y, n + 1,
                 {eq_u, gt_u, lt_u}, {eq_s, gt_s, lt_s});
    endtask

    task automatic run_stream(input int cnt);
        logic [W-1:0] xs[$];
        logic [W-1:0] ys[$];
        int n;
        for (int k = 0; k < cnt + 1; k++) begin
            xs.push_back(W'($urandom));
            ys.push_back((k % 3 == 0) ? xs[k] : W'($urandom));
        end
        @(negedge clk);
        start = 1'b1; a = xs[0]; b = ys[0];
        @(posedge clk); #1;
        a = xs[1]; b = ys[1];
        wait_done(0, n);
        check("stream_lat0", n + 1, ref_lat(xs[0], ys[0]));
        check_result(xs[0], ys[0]);
        for (int k = 1; k < cnt; k++) begin
            @(posedge clk); #1;
            check("stream_idle", {done_u, busy_u, busy_s}, 0);
            @(posedge clk); #1;
            check("stream_accept", {busy_u, busy_s}, 2'b11);
            a = xs[k + 1]; b = ys[k + 1];
            wait_done(0, n);
            check("stream_spacing", n + 2, ref_lat(xs[k], ys[k]) + 1);
            check_result(xs[k], ys[k]);
            $display("stream k=%0d a=%02h b=%02h spacing=%0d", k, xs[k], ys[k], n + 2);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("stream_end", {done_u, busy_u}, 0);
    endtask

    initial begin
        logic [W-1:0] x, y;
        int seen_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy_u, done_u, eq_u, gt_u, lt_u, busy_s, done_s, eq_s, gt_s, lt_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp(8'h5A, 8'h5A, 0);
        run_cmp(8'h80, 8'h7F, 0);
        run_cmp(8'h03, 8'h02, 0);
        run_cmp(8'h02, 8'h03, 0);
        run_cmp(8'h10, 8'h20, 3);

        // Abort a scan with reset and make sure no done escapes.
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'hC3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy_u, done_u, eq_u, gt_u, lt_u, busy_s, done_s, eq_s, gt_s, lt_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_u || done_s || busy_u) seen_done++;
        end
        check("no_done_after_abort", seen_done, 0);
        $display("reset abort: activity after release=%0d", seen_done);
        run_cmp(8'h01, 8'h01, 0);

        for (int k = 0; k < 30; k++) begin
            x = W'($urandom);
            case (k % 3)
                0:       y = x;
                1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            run_cmp(x, y, 0);
        end

        run_stream(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
